// File: rtl/mul_pkg.sv
// Shared types and defaults for the sequential shift-and-add multiplier.
package mul_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int N_DEFAULT = 4;

endpackage : mul_pkg

// File: rtl/mul_step.sv
// One shift-and-add step: conditionally add the multiplicand, then shift it.
// This holds the only adder in the multiplier and is reused every RUN cycle.
module mul_step #(
   parameter int N = 4
) (
   input  logic [2*N-1:0] acc_i,
   input  logic [2*N-1:0] mcand_i,
   input  logic           mplier_lsb_i,
   output logic [2*N-1:0] acc_next_o,
   output logic [2*N-1:0] mcand_next_o
);

   // The sum cannot overflow 2N bits: the largest product is (2^N-1)^2.
   assign acc_next_o   = mplier_lsb_i ? (acc_i + mcand_i) : acc_i;
   assign mcand_next_o = mcand_i << 1;

endmodule : mul_step

// File: rtl/mul_seq_ctrl.sv
// Sequential unsigned multiplier controller: start/done handshake around a
// single reused add/shift step, fixed latency of N RUN cycles.
module mul_seq_ctrl
   import mul_pkg::*;
#(
   parameter int N = N_DEFAULT
) (
   input  logic           CLK,
   input  logic           RESET,
   input  logic           start,
   input  logic [N-1:0]   A,
   input  logic [N-1:0]   B,
   output logic           busy,
   output logic           done,
   output logic [2*N-1:0] Y
);

   localparam int             CNT_W    = (N > 1) ? $clog2(N) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

   state_t           state_q;
   logic [2*N-1:0]   acc_q;
   logic [2*N-1:0]   mcand_q;
   logic [N-1:0]     mplier_q;
   logic [CNT_W-1:0] cnt_q;
   logic             busy_q;
   logic             done_q;

   logic [2*N-1:0]   acc_d;
   logic [2*N-1:0]   mcand_d;

   mul_step #(.N(N)) u_step (
      .acc_i        (acc_q),
      .mcand_i      (mcand_q),
      .mplier_lsb_i (mplier_q[0]),
      .acc_next_o   (acc_d),
      .mcand_next_o (mcand_d)
   );

   // NOTE: all state lives in one clocked block with non-blocking assignments,
   // so every register samples the pre-edge values of its neighbours.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_q  <= IDLE;
         acc_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         cnt_q    <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         unique case (state_q)
            IDLE, DONE: begin
               // DONE accepts a new request directly, enabling back-to-back use.
               if (start) begin
                  mcand_q  <= {{N{1'b0}}, A};
                  mplier_q <= B;
                  acc_q    <= '0;
                  cnt_q    <= '0;
                  state_q  <= RUN;
                  busy_q   <= 1'b1;
                  done_q   <= 1'b0;
               end
            end
            RUN: begin
               acc_q    <= acc_d;
               mcand_q  <= mcand_d;
               mplier_q <= mplier_q >> 1;
               cnt_q    <= cnt_q + 1'b1;
               if (cnt_q == CNT_LAST) begin
                  state_q <= DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign Y    = acc_q;

endmodule : mul_seq_ctrl

// File: tb/tb_mul_seq_ctrl.sv
// Scoreboard bench for mul_seq_ctrl (N=4): expected products are queued at
// issue time and compared when done rises, together with the latency.
module tb_mul_seq_ctrl;

   localparam int N     = 4;
   localparam int LIMIT = 4 * N;

   logic           CLK;
   logic           RESET;
   logic           start;
   logic [N-1:0]   A;
   logic [N-1:0]   B;
   logic           busy;
   logic           done;
   logic [2*N-1:0] Y;

   int n_checks = 0;
   int n_errors = 0;
   logic [2*N-1:0] exp_q[$];

   mul_seq_ctrl #(.N(N)) dut (
      .CLK   (CLK),
      .RESET (RESET),
      .start (start),
      .A     (A),
      .B     (B),
      .busy  (busy),
      .done  (done),
      .Y     (Y)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Drive start for exactly one rising edge, then scramble A/B; returns at
   // the falling edge after the accepting edge.
   task automatic issue(input logic [N-1:0] a, input logic [N-1:0] b);
      logic [2*N-1:0] ea;
      logic [2*N-1:0] eb;
      @(negedge CLK);
      start = 1'b1;
      A     = a;
      B     = b;
      ea    = {{N{1'b0}}, a};
      eb    = {{N{1'b0}}, b};
      exp_q.push_back(ea * eb);
      @(negedge CLK);
      start = 1'b0;
      A     = N'($urandom);
      B     = N'($urandom);
   endtask

   // Wait for done with a bounded budget; waited = falling edges already spent
   // since the accepting edge. done must appear exactly N edges after it.
   task automatic wait_done(input string tag, input int waited);
      int cyc;
      int busy_n;
      logic [2*N-1:0] e;
      cyc    = waited;
      busy_n = 0;
      while (!done && cyc < LIMIT) begin
         if (busy) busy_n++;
         @(negedge CLK);
         cyc++;
      end
      check({tag, "_latency"}, 32'(cyc), 32'(N));
      check({tag, "_busy_cycles"}, 32'(busy_n), 32'(N - waited));
      check({tag, "_busy_low"}, 32'(busy), 32'd0);
      if (exp_q.size() == 0) begin
         check({tag, "_scoreboard_empty"}, 32'(exp_q.size()), 32'd1);
      end else begin
         e = exp_q.pop_front();
         check({tag, "_Y"}, 32'(Y), 32'(e));
      end
   endtask

   initial begin
      RESET = 1'b1;
      start = 1'b0;
      A     = '0;
      B     = '0;
      repeat (2) @(negedge CLK);
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_done", 32'(done), 32'd0);
      check("reset_Y", 32'(Y), 32'd0);
      RESET = 1'b0;

      // Zero operands still take the full fixed latency.
      issue(4'd0, 4'd0);
      check("t1_busy_after_accept", 32'(busy), 32'd1);
      wait_done("t1", 0);

      // Result holds while idle in DONE.
      issue(4'd15, 4'd15);
      wait_done("t2", 0);
      for (int i = 0; i < 5; i++) begin
         @(negedge CLK);
         check("t2_hold_done", 32'(done), 32'd1);
         check("t2_hold_Y", 32'(Y), 32'd225);
      end

      // Back-to-back start accepted directly from DONE.
      issue(4'd12, 4'd7);
      wait_done("t3a", 0);
      issue(4'd3, 4'd5);
      check("t3_done_drop", 32'(done), 32'd0);
      check("t3_busy_rise", 32'(busy), 32'd1);
      wait_done("t3b", 0);

      // start while busy is ignored.
      issue(4'd9, 4'd9);
      @(negedge CLK);
      start = 1'b1;
      A     = 4'd1;
      B     = 4'd1;
      @(negedge CLK);
      start = 1'b0;
      wait_done("t4", 2);

      // Reset mid-RUN, between clock edges.
      issue(4'd13, 4'd11);
      @(negedge CLK);
      #2 RESET = 1'b1;
      #1;
      check("t5_rst_busy", 32'(busy), 32'd0);
      check("t5_rst_done", 32'(done), 32'd0);
      check("t5_rst_Y", 32'(Y), 32'd0);
      exp_q.delete();
      @(negedge CLK);
      RESET = 1'b0;
      issue(4'd13, 4'd11);
      wait_done("t5", 0);

      // Exhaustive sweep of all operand pairs.
      for (int a = 0; a < (1 << N); a++) begin
         for (int b = 0; b < (1 << N); b++) begin
            issue(N'(a), N'(b));
            wait_done("sweep", 0);
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule : tb_mul_seq_ctrl
